// File: rtl/button_conditioner_pkg.sv
// Shared types and constants for the button conditioner.
//   hold_state_t : per-channel hold FSM state encoding
//   DEF_*        : default cycle counts and widths
//   fits_width() : true when a cycle count is representable in a counter width
package button_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } hold_state_t;

  localparam int unsigned DEF_N_BTN           = 4;
  localparam int unsigned DEF_CNT_W           = 24;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 255;
  localparam int unsigned DEF_LONG_CYCLES     = 5_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES   = 1_000_000;

  function automatic bit fits_width(input int unsigned value, input int unsigned width);
    if (width >= 32) return 1'b1;
    return (value >> width) == 0;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board-side driver and the conditioner.
//   i_async_btn  : raw asynchronous button levels (driven by master)
//   o_level      : debounced level
//   o_press      : one-cycle pulse on accepted press
//   o_release    : one-cycle pulse on accepted release
//   o_long_press : one-cycle pulse once per press after the long-hold time
//   o_repeat     : one-cycle pulse train while held past long-press
interface button_conditioner_if
  import button_pkg::*;
#(
  parameter int unsigned N_BTN = DEF_N_BTN
) ();

  logic [N_BTN-1:0] i_async_btn;
  logic [N_BTN-1:0] o_level;
  logic [N_BTN-1:0] o_press;
  logic [N_BTN-1:0] o_release;
  logic [N_BTN-1:0] o_long_press;
  logic [N_BTN-1:0] o_repeat;

  modport master (
    output i_async_btn,
    input  o_level, o_press, o_release, o_long_press, o_repeat
  );

  modport slave (
    input  i_async_btn,
    output o_level, o_press, o_release, o_long_press, o_repeat
  );

endinterface

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, hold FSM.
//   clk, rst_n   : clock, synchronous active-low reset
//   i_async_btn  : raw button input
//   o_level      : debounced level
//   o_press/o_release/o_long_press/o_repeat : registered one-cycle pulses
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long_press,
  output logic o_repeat
);

  localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam bit               REP_EN  = (REPEAT_CYCLES != 0);
  localparam logic [CNT_W-1:0] REP_TC  = REP_EN ? CNT_W'(REPEAT_CYCLES - 1) : '0;

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_dcnt;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] w_hcnt_nxt;
  hold_state_t      r_state;
  hold_state_t      w_state_nxt;
  logic             w_mismatch;
  logic             w_accept;
  logic             w_long_nxt;
  logic             w_repeat_nxt;

  assign w_mismatch = (r_sync2 != o_level);
  assign w_accept   = w_mismatch && (r_dcnt == DEB_TC);

  // Synchroniser, debounce window and press/release pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_dcnt    <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      r_sync1   <= i_async_btn;
      r_sync2   <= r_sync1;
      o_press   <= w_accept & ~o_level;
      o_release <= w_accept & o_level;
      if (w_accept) begin
        o_level <= ~o_level;
        r_dcnt  <= '0;
      end else if (w_mismatch) begin
        r_dcnt <= r_dcnt + CNT_W'(1);
      end else begin
        r_dcnt <= '0;
      end
    end
  end

  // Hold FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
    end
  end

  // Hold FSM next state; an accepted edge outside IDLE is always a release
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = PRESSED;
          w_hcnt_nxt  = '0;
        end
      end
      PRESSED: begin
        if (w_accept) begin
          w_state_nxt = IDLE;
          w_hcnt_nxt  = '0;
        end else if (r_hcnt == LONG_TC) begin
          w_state_nxt = HELD;
          w_hcnt_nxt  = '0;
        end else begin
          w_hcnt_nxt = r_hcnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (w_accept) begin
          w_state_nxt = IDLE;
          w_hcnt_nxt  = '0;
        end else if (!REP_EN || (r_hcnt == REP_TC)) begin
          w_hcnt_nxt = '0;
        end else begin
          w_hcnt_nxt = r_hcnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_hcnt_nxt  = '0;
      end
    endcase
  end

  // Hold FSM outputs; release suppresses a coincident long/repeat
  always_comb begin
    w_long_nxt   = 1'b0;
    w_repeat_nxt = 1'b0;
    case (r_state)
      PRESSED: w_long_nxt   = !w_accept && (r_hcnt == LONG_TC);
      HELD:    w_repeat_nxt = REP_EN && !w_accept && (r_hcnt == REP_TC);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_long_press <= 1'b0;
      o_repeat     <= 1'b0;
    end else begin
      o_long_press <= w_long_nxt;
      o_repeat     <= w_repeat_nxt;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end: N_BTN independent button_channel instances.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : button_conditioner_if slave (raw inputs in, level and pulses out)
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_BTN           = DEF_N_BTN,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input logic                 clk,
  input logic                 rst_n,
  button_conditioner_if.slave bus
);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_min
    $error("button_conditioner: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
  end

  if (!fits_width(DEBOUNCE_CYCLES, CNT_W) || !fits_width(LONG_CYCLES, CNT_W) ||
      !fits_width(REPEAT_CYCLES, CNT_W)) begin : g_bad_width
    $error("button_conditioner: a cycle count does not fit in CNT_W");
  end

  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;
  logic [N_BTN-1:0] w_long_press;
  logic [N_BTN-1:0] w_repeat;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    button_channel #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_async_btn (bus.i_async_btn[g]),
      .o_level     (w_level[g]),
      .o_press     (w_press[g]),
      .o_release   (w_release[g]),
      .o_long_press(w_long_press[g]),
      .o_repeat    (w_repeat[g])
    );
  end

  assign bus.o_level      = w_level;
  assign bus.o_press      = w_press;
  assign bus.o_release    = w_release;
  assign bus.o_long_press = w_long_press;
  assign bus.o_repeat     = w_repeat;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: stimulus pushes expected pulses (dut, channel, kind, edge);
// a negedge monitor matches every observed pulse and flags missing ones.
module tb_button_conditioner;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_REP   = 3;

  typedef struct {
    int dut;
    int ch;
    int kind;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   mon_en = 1'b0;

  button_conditioner_if #(.N_BTN(2)) a_if ();
  button_conditioner_if #(.N_BTN(2)) b_if ();

  button_conditioner #(
    .N_BTN(2), .CNT_W(24), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));

  button_conditioner #(
    .N_BTN(2), .CNT_W(24), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(0)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] pulses(input int d, input int k);
    if (d == 0) begin
      case (k)
        K_PRESS: return a_if.o_press;
        K_REL:   return a_if.o_release;
        K_LONG:  return a_if.o_long_press;
        default: return a_if.o_repeat;
      endcase
    end
    case (k)
      K_PRESS: return b_if.o_press;
      K_REL:   return b_if.o_release;
      K_LONG:  return b_if.o_long_press;
      default: return b_if.o_repeat;
    endcase
  endfunction

  task automatic sb_expect(input int d, input int ch, input int k, input int t);
    exp_t e;
    e.dut = d; e.ch = ch; e.kind = k; e.cyc = t;
    sbq.push_back(e);
  endtask

  task automatic sb_match(input int d, input int ch, input int k);
    int idx;
    idx = -1;
    for (int i = 0; i < sbq.size(); i++)
      if (idx < 0 && sbq[i].dut == d && sbq[i].ch == ch && sbq[i].kind == k && sbq[i].cyc == cyc)
        idx = i;
    total++;
    if (idx < 0) begin
      bad++;
      $display("FAIL unexpected pulse dut=%0d ch=%0d kind=%0d edge=%0d: got=1 want=0", d, ch, k, cyc);
    end else begin
      sbq.delete(idx);
    end
  endtask

  // Monitor: match observed pulses, then retire expectations that never showed up
  always @(negedge clk) begin
    logic [1:0] p;
    if (mon_en) begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 4; k++) begin
          p = pulses(d, k);
          for (int ch = 0; ch < 2; ch++)
            if (p[ch] === 1'b1) sb_match(d, ch, k);
        end
      for (int i = sbq.size() - 1; i >= 0; i--)
        if (sbq[i].cyc < cyc) begin
          total++;
          bad++;
          $display("FAIL missing pulse dut=%0d ch=%0d kind=%0d edge=%0d: got=0 want=1",
                   sbq[i].dut, sbq[i].ch, sbq[i].kind, sbq[i].cyc);
          sbq.delete(i);
        end
    end
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " a.level"},   a_if.o_level,      2'b00);
    chk({tag, " a.press"},   a_if.o_press,      2'b00);
    chk({tag, " a.release"}, a_if.o_release,    2'b00);
    chk({tag, " a.long"},    a_if.o_long_press, 2'b00);
    chk({tag, " a.repeat"},  a_if.o_repeat,     2'b00);
    chk({tag, " b.level"},   b_if.o_level,      2'b00);
  endtask

  int t;

  initial begin
    a_if.i_async_btn = 2'b00;
    b_if.i_async_btn = 2'b00;

    // Reset state
    tick(1);
    chk_all_zero("reset");
    tick(2);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick(3);

    // Bounce then hold; long hold with release coinciding with a repeat terminal count
    a_if.i_async_btn = 2'b01; tick(2);
    a_if.i_async_btn = 2'b00; tick(2);
    a_if.i_async_btn = 2'b01; tick(2);
    a_if.i_async_btn = 2'b00; tick(2);
    a_if.i_async_btn = 2'b01;
    t = cyc + 1;
    sb_expect(0, 0, K_PRESS, t + 5);
    sb_expect(0, 0, K_LONG,  t + 25);
    sb_expect(0, 0, K_REP,   t + 30);
    sb_expect(0, 0, K_REP,   t + 35);
    sb_expect(0, 0, K_REP,   t + 40);
    sb_expect(0, 0, K_REL,   t + 45);
    wait_until(t + 4);
    chk("bounce level before window", a_if.o_level, 2'b00);
    wait_until(t + 5);
    chk("bounce level at window", a_if.o_level, 2'b01);
    wait_until(t + 39);
    a_if.i_async_btn = 2'b00;
    wait_until(t + 45);
    chk("long hold level after release", a_if.o_level, 2'b00);
    tick(15);

    // Short press
    a_if.i_async_btn = 2'b01;
    t = cyc + 1;
    sb_expect(0, 0, K_PRESS, t + 5);
    sb_expect(0, 0, K_REL,   t + 15);
    wait_until(t + 9);
    a_if.i_async_btn = 2'b00;
    wait_until(t + 30);

    // Glitch one cycle shorter than the window on channel 1
    a_if.i_async_btn = 2'b10; tick(3);
    a_if.i_async_btn = 2'b00; tick(10);
    chk("glitch level", a_if.o_level, 2'b00);

    // Independent channels
    a_if.i_async_btn = 2'b11;
    t = cyc + 1;
    sb_expect(0, 0, K_PRESS, t + 5);
    sb_expect(0, 1, K_PRESS, t + 5);
    sb_expect(0, 1, K_REL,   t + 17);
    sb_expect(0, 0, K_LONG,  t + 25);
    sb_expect(0, 0, K_REP,   t + 30);
    sb_expect(0, 0, K_REP,   t + 35);
    sb_expect(0, 0, K_REL,   t + 37);
    wait_until(t + 11);
    a_if.i_async_btn = 2'b01;
    wait_until(t + 20);
    chk("independent level", a_if.o_level, 2'b01);
    wait_until(t + 31);
    a_if.i_async_btn = 2'b00;
    wait_until(t + 37);
    tick(15);

    // Reset while HELD, button kept high through reset
    a_if.i_async_btn = 2'b01;
    t = cyc + 1;
    sb_expect(0, 0, K_PRESS, t + 5);
    sb_expect(0, 0, K_LONG,  t + 25);
    wait_until(t + 27);
    rst_n = 1'b0;
    tick(1);
    chk_all_zero("reset while held");
    tick(2);
    rst_n = 1'b1;
    sb_expect(0, 0, K_PRESS, t + 36);
    sb_expect(0, 0, K_LONG,  t + 56);
    sb_expect(0, 0, K_REP,   t + 61);
    sb_expect(0, 0, K_REL,   t + 63);
    wait_until(t + 36);
    chk("level after reset re-press", a_if.o_level, 2'b01);
    wait_until(t + 57);
    a_if.i_async_btn = 2'b00;
    wait_until(t + 63);
    tick(10);

    // Repeat disabled build: single long_press, no repeats
    b_if.i_async_btn = 2'b01;
    t = cyc + 1;
    sb_expect(1, 0, K_PRESS, t + 5);
    sb_expect(1, 0, K_LONG,  t + 25);
    sb_expect(1, 0, K_REL,   t + 65);
    wait_until(t + 50);
    chk("no-repeat level held", b_if.o_level, 2'b01);
    wait_until(t + 59);
    b_if.i_async_btn = 2'b00;
    wait_until(t + 65);
    tick(20);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: got=%0d want=0", sbq.size());
    end
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Multi-channel button front end: synchronises N asynchronous button inputs, debounces each with a programmable stability window, and emits a debounced level plus one-cycle press, release, long-press and auto-repeat pulses per channel. It is the parametrised successor to the single-channel press-only cleaner. It sits between the board push-buttons and the clock/menu control logic, which consumes the pulses directly in the `clk` domain.

## Interface

Parameters:
- `N_BTN`, default 4: number of independent button channels.
- `CNT_W`, default 24: width of the per-channel debounce and hold counters.
- `DEBOUNCE_CYCLES`, default 255: consecutive stable cycles required to accept a level change; must be ≥1.
- `LONG_CYCLES`, default 5_000_000: cycles after the press pulse until `long_press`; must be ≥1.
- `REPEAT_CYCLES`, default 1_000_000: auto-repeat period after `long_press`; 0 disables repeat.
- Constraint: every cycle count must fit in `CNT_W`; elaboration-time error otherwise.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `async_btn` in N_BTN: raw button inputs, active-high, asynchronous.
- `level` out N_BTN: debounced button state.
- `press` out N_BTN: one-cycle pulse on accepted rising edge.
- `release` out N_BTN: one-cycle pulse on accepted falling edge.
- `long_press` out N_BTN: one-cycle pulse, at most once per press.
- `repeat` out N_BTN: one-cycle pulse train while held past long-press.

## Operation

- Channels are fully independent. There is no shared state and no priority between them.
- Synchroniser: two flops per channel, reset 0. `sync` denotes the second flop.
- Debounce: debounce counter `dcnt` increments on every edge where `sync != level`, and clears on every edge where `sync == level`. On the edge where the mismatch persists and `dcnt == DEBOUNCE_CYCLES-1`, `level` flips, `dcnt` clears, and `press` or `release` pulses on that same edge.
- Hold state machine per channel:
  - IDLE: `level`=0.
  - PRESSED: `level`=1, long not yet reached.
  - HELD: long reached.
- Transitions:
  - IDLE → PRESSED on the press pulse; hold counter `hcnt` is set to 0.
  - PRESSED: `hcnt` increments each cycle. When `hcnt` reaches LONG_CYCLES-1, `long_press` pulses, the state moves to HELD, and `hcnt` is set to 0.
  - HELD: if REPEAT_CYCLES ≠ 0, `hcnt` increments. When `hcnt` reaches REPEAT_CYCLES-1, `repeat` pulses and `hcnt` is set to 0. If REPEAT_CYCLES = 0, `hcnt` stays 0.
  - PRESSED or HELD → IDLE on the release pulse. No `long_press` or `repeat` is issued on that edge or after it.
- Release beats long/repeat: if the release pulse coincides with a `long_press` or `repeat` terminal count, only `release` fires.
- Counters never wrap. `dcnt` is bounded by DEBOUNCE_CYCLES; `hcnt` is bounded by the terminal compare.

## Timing

- Reset (`rst_n`=0 sampled at an edge): synchroniser flops, `level`, all pulse outputs, `dcnt` and `hcnt` go to 0, and the state goes to IDLE, all on that edge. Pending pulses are discarded.
- Button held across reset release: treated as a fresh press. `press` fires after the full latency.
- Latency: define the first edge that samples a new `async_btn` value as edge 0. `sync` shows the new value after edge 1. `level` and the pulse update at edge DEBOUNCE_CYCLES+1, provided the input stays stable.
- Any bounce before acceptance restarts the window. A glitch shorter than DEBOUNCE_CYCLES never reaches `level`.
- `long_press` fires LONG_CYCLES edges after the `press` edge.
- The k-th `repeat` fires k·REPEAT_CYCLES edges after the `long_press` edge.
- All outputs are registered. Every pulse is exactly one cycle wide.

## Structure

- Package `button_pkg`:
  - `hold_state_t` enum (IDLE, PRESSED, HELD).
  - Default cycle-count constants.
  - Width-check function used by the elaboration assertion.
- Sub-module `button_channel`: one channel containing the synchroniser, debounce and hold FSM. The top level instantiates it N_BTN times with a generate loop.

## Test plan

Bench configuration: N_BTN=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5. Edge 0 is the first edge sampling the final input value.

- **Bounce:** `async_btn[0]` toggles 1,0,1,0 every 2 cycles, then holds 1 → no pulses during the bounce; exactly one `press[0]` and `level[0]`=1 at edge 5.
- **Long hold:** press with `press` at edge t, hold 40 cycles → `long_press` at t+20; `repeat` at t+25, t+30, t+35; after the input drops, `release` 5 edges later; no further `repeat`.
- **Short press:** 10-cycle press → `press` then `release`; no `long_press` or `repeat`.
- **Independent channels:** both channels pressed simultaneously, channel 1 released early → independent, correctly timed pulses on each bit; no cross-talk.
- **Reset while HELD:** assert `rst_n`=0 for 3 cycles while channel 0 is HELD → all outputs 0 on the first reset edge; after release with the button still high, `press` at edge 5 and `long_press` 20 edges later.
- **Repeat disabled:** build with REPEAT_CYCLES=0, hold 60 cycles → a single `long_press` and no `repeat` pulses.
